// File: rtl/alu_sequencer.sv
// Operand/function sequencer for the 6502 ALU: one pass for binary, logic, shift
// and compare requests, plus a correction pass for decimal-mode ADC/SBC.
`ifndef REG_WIDTH
`define REG_WIDTH 8
`endif
`ifndef OPP_WIDTH
`define OPP_WIDTH 3
`endif
`ifndef SUM
`define SUM 3'd0
`endif
`ifndef AND
`define AND 3'd1
`endif
`ifndef OR
`define OR 3'd2
`endif
`ifndef XOR
`define XOR 3'd3
`endif
`ifndef SR
`define SR 3'd4
`endif

module alu_sequencer (
    input  logic                    phi1,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [`REG_WIDTH-1:0]   opnd_a,
    input  logic [`REG_WIDTH-1:0]   opnd_m,
    input  logic                    carry_flag,
    input  logic                    dec_mode,
    output logic [`REG_WIDTH-1:0]   alu_a,
    output logic [`REG_WIDTH-1:0]   alu_b,
    output logic [`OPP_WIDTH-1:0]   alu_func,
    output logic                    alu_carry_in,
    input  logic [`REG_WIDTH-1:0]   alu_add,
    input  logic                    alu_carry_out,
    input  logic                    alu_wout,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [`REG_WIDTH-1:0]   result,
    output logic                    result_we,
    output logic [3:0]              flags,
    output logic [3:0]              flags_upd
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PASS1 = 3'd1;
    localparam logic [2:0] S_CAP1  = 3'd2;
    localparam logic [2:0] S_PASS2 = 3'd3;
    localparam logic [2:0] S_CAP2  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [2:0] OP_ADC = 3'd0;
    localparam logic [2:0] OP_SBC = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ORA = 3'd3;
    localparam logic [2:0] OP_EOR = 3'd4;
    localparam logic [2:0] OP_ASL = 3'd5;
    localparam logic [2:0] OP_CMP = 3'd6;
    localparam logic [2:0] OP_RSV = 3'd7;

    logic [2:0]             r_state;
    logic [2:0]             r_op;
    logic [`REG_WIDTH-1:0]  r_a, r_m, r_r1, r_adj, r_result;
    logic                   r_c, r_d, r_v, r_cdec;
    logic                   r_done, r_err, r_we;
    logic [3:0]             r_flags, r_upd;

    logic [`OPP_WIDTH-1:0]  w_func;
    logic [`REG_WIDTH-1:0]  w_b, w_adj;
    logic                   w_cin, w_h, w_c1, w_v, w_lo, w_hi, w_cdec, w_dec;
    logic [3:0]             w_mask, w_flags1, w_flags2;

    // First-pass operand selection; stays stable through CAP1 for the V/h terms.
    always_comb begin
        w_func = `SUM;
        w_b    = r_m;
        w_cin  = 1'b0;
        case (r_op)
            OP_ADC: w_cin = r_c;
            OP_SBC: begin w_b = ~r_m; w_cin = r_c; end
            OP_CMP: begin w_b = ~r_m; w_cin = 1'b1; end
            OP_AND: w_func = `AND;
            OP_ORA: w_func = `OR;
            OP_EOR: w_func = `XOR;
            OP_ASL: begin w_func = `SR; w_b = 8'h01; end
            default: ;
        endcase
    end

    always_comb begin
        alu_func     = `SUM;
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        if (r_state == S_PASS1) begin
            alu_func     = w_func;
            alu_a        = r_a;
            alu_b        = w_b;
            alu_carry_in = w_cin;
        end else if (r_state == S_PASS2) begin
            alu_a = r_r1;
            alu_b = r_adj;
        end
    end

    assign w_h  = ({1'b0, r_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0, w_cin}) > 5'd15;
    assign w_c1 = (r_op == OP_ASL) ? r_a[`REG_WIDTH-1] : alu_carry_out;
    assign w_v  = (r_a[`REG_WIDTH-1] == w_b[`REG_WIDTH-1]) &&
                  (alu_add[`REG_WIDTH-1] != r_a[`REG_WIDTH-1]);
    assign w_dec = r_d && (r_op == OP_ADC || r_op == OP_SBC);

    // Decimal correction is decided from the binary pass and applied as a second SUM.
    always_comb begin
        w_lo = (alu_add[3:0] > 4'd9) || w_h;
        w_hi = (alu_add > 8'h99) || w_c1;
        if (r_op == OP_SBC) begin
            w_adj  = (w_h ? 8'h00 : 8'hFA) + (w_c1 ? 8'h00 : 8'hA0);
            w_cdec = w_c1;
        end else begin
            w_adj  = (w_lo ? 8'h06 : 8'h00) + (w_hi ? 8'h60 : 8'h00);
            w_cdec = w_c1 || w_hi;
        end
    end

    always_comb begin
        case (r_op)
            OP_ADC, OP_SBC:         w_mask = 4'b1111;
            OP_CMP:                 w_mask = 4'b1011;
            OP_ASL:                 w_mask = 4'b1001;
            OP_AND, OP_ORA, OP_EOR: w_mask = 4'b1000;
            default:                w_mask = 4'b0000;
        endcase
    end

    assign w_flags1 = {alu_add[`REG_WIDTH-1], w_v, alu_add == '0, w_c1} & w_mask;
    assign w_flags2 = {alu_add[`REG_WIDTH-1], r_v, alu_add == '0, r_cdec} & w_mask;

    always_ff @(posedge phi1) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_m      <= '0;
            r_c      <= 1'b0;
            r_d      <= 1'b0;
            r_r1     <= '0;
            r_adj    <= '0;
            r_v      <= 1'b0;
            r_cdec   <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_we     <= 1'b0;
            r_flags  <= '0;
            r_upd    <= '0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_flags <= '0;
            r_upd   <= '0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op <= op;
                    r_a  <= opnd_a;
                    r_m  <= opnd_m;
                    r_c  <= carry_flag;
                    r_d  <= dec_mode;
                    if (op == OP_RSV) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_state <= S_PASS1;
                    end
                end
                S_PASS1: r_state <= S_CAP1;
                S_CAP1: begin
                    r_r1   <= alu_add;
                    r_v    <= w_v;
                    r_adj  <= w_adj;
                    r_cdec <= w_cdec;
                    if (!alu_wout) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_dec) begin
                        r_state <= S_PASS2;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_flags <= w_flags1;
                        r_upd   <= w_mask;
                        if (r_op != OP_CMP) begin
                            r_result <= alu_add;
                            r_we     <= 1'b1;
                        end
                    end
                end
                S_PASS2: r_state <= S_CAP2;
                S_CAP2: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    if (!alu_wout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_result <= alu_add;
                        r_we     <= 1'b1;
                        r_flags  <= w_flags2;
                        r_upd    <= w_mask;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign result    = r_result;
    assign result_we = r_we;
    assign flags     = r_flags;
    assign flags_upd = r_upd;
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: registered ALU stand-in plus an
// arithmetic (binary/BCD) reference model of each request.
`ifndef OPP_WIDTH
`define OPP_WIDTH 3
`endif
`ifndef SUM
`define SUM 3'd0
`endif
`ifndef AND
`define AND 3'd1
`endif
`ifndef OR
`define OR 3'd2
`endif
`ifndef XOR
`define XOR 3'd3
`endif
`ifndef SR
`define SR 3'd4
`endif

module tb_alu_sequencer;
    logic                  phi1 = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [2:0]            op = '0;
    logic [7:0]            opnd_a = '0, opnd_m = '0;
    logic                  carry_flag = 1'b0, dec_mode = 1'b0;
    logic [7:0]            alu_a, alu_b;
    logic [`OPP_WIDTH-1:0] alu_func;
    logic                  alu_carry_in;
    logic [7:0]            alu_add = '0;
    logic                  alu_carry_out = 1'b0;
    logic                  alu_wout = 1'b1;
    logic                  busy, done, err, result_we;
    logic [7:0]            result;
    logic [3:0]            flags, flags_upd;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [7:0] exp_result = '0;

    alu_sequencer dut (
        .phi1(phi1), .reset(reset), .start(start), .op(op),
        .opnd_a(opnd_a), .opnd_m(opnd_m), .carry_flag(carry_flag), .dec_mode(dec_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_carry_in(alu_carry_in),
        .alu_add(alu_add), .alu_carry_out(alu_carry_out), .alu_wout(alu_wout),
        .busy(busy), .done(done), .err(err), .result(result), .result_we(result_we),
        .flags(flags), .flags_upd(flags_upd)
    );

    always #5 phi1 = ~phi1;

    // ALU stand-in: registered on phi1; its SR function shifts a left by b.
    always @(posedge phi1) begin
        case (alu_func)
            `AND: begin alu_add <= alu_a & alu_b; alu_carry_out <= 1'b0; end
            `OR:  begin alu_add <= alu_a | alu_b; alu_carry_out <= 1'b0; end
            `XOR: begin alu_add <= alu_a ^ alu_b; alu_carry_out <= 1'b0; end
            `SR:  begin alu_add <= alu_a << alu_b[2:0]; alu_carry_out <= 1'b0; end
            default: {alu_carry_out, alu_add} <= {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
        endcase
    end

    function automatic int bcd(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] tobcd(input int s);
        return {4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic void model(input logic [2:0] f_op, input logic [7:0] a, m,
                                  input logic c, d, output logic [7:0] res,
                                  output logic we, er, output logic [3:0] fl, up,
                                  output int lat);
        int s, sv;
        logic cc, v;
        res = '0; we = 1'b1; er = 1'b0; up = '0; lat = 3; cc = 1'b0; v = 1'b0; s = 0; sv = 0;
        case (f_op)
            3'd0: begin
                sv = int'($signed(a)) + int'($signed(m)) + int'(c);
                if (d) begin
                    s = bcd(a) + bcd(m) + int'(c); cc = (s > 99); res = tobcd(s % 100); lat = 5;
                end else begin
                    s = int'(a) + int'(m) + int'(c); cc = (s > 255); res = 8'(s);
                end
                up = 4'b1111;
            end
            3'd1: begin
                sv = int'($signed(a)) - int'($signed(m)) - (1 - int'(c));
                if (d) begin
                    s = bcd(a) - bcd(m) - (1 - int'(c)); cc = (s >= 0);
                    if (s < 0) s = s + 100;
                    res = tobcd(s); lat = 5;
                end else begin
                    s = int'(a) - int'(m) - (1 - int'(c)); cc = (s >= 0); res = 8'(s);
                end
                up = 4'b1111;
            end
            3'd2: begin res = a & m; up = 4'b1000; end
            3'd3: begin res = a | m; up = 4'b1000; end
            3'd4: begin res = a ^ m; up = 4'b1000; end
            3'd5: begin res = {a[6:0], 1'b0}; cc = a[7]; up = 4'b1001; end
            3'd6: begin
                s = int'(a) - int'(m); res = 8'(s); cc = (s >= 0); we = 1'b0; up = 4'b1011;
            end
            default: begin we = 1'b0; er = 1'b1; lat = 1; end
        endcase
        v = (sv > 127) || (sv < -128);
        fl = {res[7], v, res == 8'h00, cc} & up;
    endfunction

    // Drives one request from a negedge, scrambles inputs after the sampling edge,
    // and returns what was seen in the done cycle and the cycle after it.
    task automatic run_op(input logic [2:0] t_op, input logic [7:0] a, m, input logic c, d,
                          output int lat, output logic [7:0] o_res, o_hold,
                          output logic o_we, o_err, output logic [3:0] o_fl, o_up,
                          output logic o_pulse);
        op = t_op; opnd_a = a; opnd_m = m; carry_flag = c; dec_mode = d; start = 1'b1;
        @(negedge phi1);
        start = 1'b0;
        op = 3'($urandom); opnd_a = 8'($urandom); opnd_m = 8'($urandom);
        carry_flag = 1'($urandom); dec_mode = 1'($urandom);
        lat = 0; o_res = '0; o_we = 1'b0; o_err = 1'b0; o_fl = '0; o_up = '0;
        for (int k = 1; k <= 8; k++) begin
            if (done) begin
                lat = k; o_res = result; o_we = result_we; o_err = err; o_fl = flags; o_up = flags_upd;
                break;
            end
            @(negedge phi1);
        end
        @(negedge phi1);
        o_pulse = (done == 1'b0);
        o_hold = result;
    endtask

    task automatic test_reset();
        logic [36:0] obs;
        reset = 1'b1; start = 1'b1; op = 3'd0; opnd_a = 8'h11; opnd_m = 8'h22;
        repeat (2) @(negedge phi1);
        obs = {busy, done, err, result, result_we, flags, flags_upd, alu_a, alu_b, alu_carry_in};
        n_tests++;
        if (obs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        n_tests++;
        if (alu_func !== `SUM) begin
            n_fail++; $display("FAIL reset_func: got %0d expected %0d", alu_func, `SUM);
        end
        reset = 1'b0; start = 1'b0;
        @(negedge phi1);
        exp_result = '0;
    endtask

    task automatic test_directed();
        logic [19:0] vec [10];
        logic [7:0] e_res, o_res, o_hold;
        logic e_we, e_err, o_we, o_err, o_pulse;
        logic [3:0] e_fl, e_up, o_fl, o_up;
        int e_lat, lat;
        vec = '{ {3'd0, 8'h50, 8'h50, 1'b0}, {3'd0, 8'h58, 8'h46, 1'b1}, {3'd0, 8'h19, 8'h28, 1'b0},
                 {3'd1, 8'h40, 8'h13, 1'b1}, {3'd1, 8'h46, 8'h12, 1'b1}, {3'd6, 8'h10, 8'h20, 1'b0},
                 {3'd5, 8'h81, 8'h00, 1'b0}, {3'd2, 8'hF0, 8'h3C, 1'b1}, {3'd4, 8'hAA, 8'hAA, 1'b0},
                 {3'd1, 8'h00, 8'h01, 1'b1} };
        for (int i = 0; i < 10; i++) begin
            logic d;
            d = (i >= 1 && i <= 4) || i == 7 || i == 9;
            model(vec[i][19:17], vec[i][16:9], vec[i][8:1], vec[i][0], d, e_res, e_we, e_err, e_fl, e_up, e_lat);
            run_op(vec[i][19:17], vec[i][16:9], vec[i][8:1], vec[i][0], d,
                   lat, o_res, o_hold, o_we, o_err, o_fl, o_up, o_pulse);
            if (e_we) exp_result = e_res;
            n_tests++;
            if (lat != e_lat) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, e_lat);
            end
            n_tests++;
            if ({o_res, o_we, o_err, o_fl, o_up} !== {exp_result, e_we, e_err, e_fl, e_up}) begin
                n_fail++;
                $display("FAIL dir%0d_outputs: got res=%h we=%b err=%b fl=%b upd=%b expected res=%h we=%b err=%b fl=%b upd=%b",
                         i, o_res, o_we, o_err, o_fl, o_up, exp_result, e_we, e_err, e_fl, e_up);
            end
            n_tests++;
            if (o_pulse !== 1'b1 || o_hold !== exp_result) begin
                n_fail++; $display("FAIL dir%0d_hold: got pulse_ok=%b res=%h expected 1 %h", i, o_pulse, o_hold, exp_result);
            end
        end
    endtask

    task automatic test_busy_start();
        int cnt;
        logic [7:0] seen;
        cnt = 0; seen = '0;
        op = 3'd0; opnd_a = 8'h12; opnd_m = 8'h34; carry_flag = 1'b0; dec_mode = 1'b0; start = 1'b1;
        @(negedge phi1);
        op = 3'd2; opnd_a = 8'hFF; opnd_m = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) start = 1'b0;
            if (done) begin cnt++; seen = result; end
            @(negedge phi1);
        end
        exp_result = 8'h46;
        n_tests++;
        if (cnt != 1) begin
            n_fail++; $display("FAIL busy_done_count: got %0d expected 1", cnt);
        end
        n_tests++;
        if (seen !== 8'h46) begin
            n_fail++; $display("FAIL busy_result: got %h expected 46", seen);
        end
    endtask

    task automatic test_op7();
        logic [7:0] o_res, o_hold;
        logic o_we, o_err, o_pulse;
        logic [3:0] o_fl, o_up;
        int lat;
        run_op(3'd7, 8'h55, 8'h66, 1'b1, 1'b0, lat, o_res, o_hold, o_we, o_err, o_fl, o_up, o_pulse);
        n_tests++;
        if (lat != 1 || {o_res, o_we, o_err, o_fl, o_up} !== {exp_result, 1'b0, 1'b1, 8'h00} || o_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL op7_err: got lat=%0d res=%h we=%b err=%b fl=%b upd=%b expected lat=1 res=%h we=0 err=1 fl=0 upd=0",
                     lat, o_res, o_we, o_err, o_fl, o_up, exp_result);
        end
    endtask

    task automatic test_wout();
        logic [7:0] o_res, o_hold;
        logic o_we, o_err, o_pulse;
        logic [3:0] o_fl, o_up;
        int lat;
        alu_wout = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_op(3'd0, 8'h58, 8'h46, 1'b1, 1'(i), lat, o_res, o_hold, o_we, o_err, o_fl, o_up, o_pulse);
            n_tests++;
            if (lat != 3 || {o_res, o_we, o_err, o_fl, o_up} !== {exp_result, 1'b0, 1'b1, 8'h00}) begin
                n_fail++;
                $display("FAIL wout%0d_err: got lat=%0d res=%h we=%b err=%b fl=%b upd=%b expected lat=3 res=%h we=0 err=1 fl=0 upd=0",
                         i, lat, o_res, o_we, o_err, o_fl, o_up, exp_result);
            end
        end
        alu_wout = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [36:0] obs;
        int cnt;
        cnt = 0;
        op = 3'd0; opnd_a = 8'h58; opnd_m = 8'h46; carry_flag = 1'b1; dec_mode = 1'b1; start = 1'b1;
        @(negedge phi1);
        start = 1'b0;
        repeat (2) @(negedge phi1);
        n_tests++;
        if ({busy, alu_func, alu_a, alu_b, alu_carry_in} !== {1'b1, `SUM, 8'h9F, 8'h66, 1'b0}) begin
            n_fail++;
            $display("FAIL pass2_drive: got busy=%b func=%0d a=%h b=%h cin=%b expected 1 %0d 9f 66 0",
                     busy, alu_func, alu_a, alu_b, alu_carry_in, `SUM);
        end
        reset = 1'b1;
        @(negedge phi1);
        obs = {busy, done, err, result, result_we, flags, flags_upd, alu_a, alu_b, alu_carry_in};
        n_tests++;
        if (obs !== '0 || alu_func !== `SUM) begin
            n_fail++; $display("FAIL reset_mid_outputs: got %h func=%0d expected 0", obs, alu_func);
        end
        reset = 1'b0;
        exp_result = '0;
        for (int k = 0; k < 8; k++) begin
            if (done) cnt++;
            @(negedge phi1);
        end
        n_tests++;
        if (cnt != 0) begin
            n_fail++; $display("FAIL reset_mid_no_done: got %0d dones expected 0", cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] a, m, e_res, o_res, o_hold;
        logic [2:0] t_op;
        logic c, d, e_we, e_err, o_we, o_err, o_pulse;
        logic [3:0] e_fl, e_up, o_fl, o_up;
        int e_lat, lat;
        for (int i = 0; i < 60; i++) begin
            t_op = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            c = 1'($urandom); d = 1'($urandom);
            a = 8'($urandom); m = 8'($urandom);
            if (d && t_op <= 3'd1) begin
                a = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                m = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            model(t_op, a, m, c, d, e_res, e_we, e_err, e_fl, e_up, e_lat);
            run_op(t_op, a, m, c, d, lat, o_res, o_hold, o_we, o_err, o_fl, o_up, o_pulse);
            if (e_we) exp_result = e_res;
            n_tests++;
            if (lat != e_lat) begin
                n_fail++; $display("FAIL rnd%0d_latency: op=%0d d=%b got %0d expected %0d", i, t_op, d, lat, e_lat);
            end
            n_tests++;
            if ({o_res, o_we, o_err, o_fl, o_up} !== {exp_result, e_we, e_err, e_fl, e_up}) begin
                n_fail++;
                $display("FAIL rnd%0d_outputs: op=%0d a=%h m=%h c=%b d=%b got res=%h we=%b err=%b fl=%b upd=%b expected res=%h we=%b err=%b fl=%b upd=%b",
                         i, t_op, a, m, c, d, o_res, o_we, o_err, o_fl, o_up, exp_result, e_we, e_err, e_fl, e_up);
            end
            n_tests++;
            if (o_pulse !== 1'b1 || o_hold !== exp_result) begin
                n_fail++; $display("FAIL rnd%0d_hold: got pulse_ok=%b res=%h expected 1 %h", i, o_pulse, o_hold, exp_result);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_busy_start();
        test_op7();
        test_wout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
